// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS pipeline stages.
//   - DATA_W / REG_ADDR_W : default datapath width and register-index width
//   - mem_state_t         : data-memory access FSM state encoding
//   - ctrl_t              : control bundle carried by the ID/EX and EX/MEM registers
//   - ctrl_gate()         : replaces a control bundle with a bubble when killed
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic MemRead;
        logic MemWrite;
        logic RegWrite;
        logic MemtoReg;
        logic Branch;
    } ctrl_t;

    // A killed instruction keeps its data but loses every side effect.
    function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic kill);
        return kill ? ctrl_t'('0) : c;
    endfunction

endpackage

// File: rtl/dmem_access_fsm.sv
// dmem_access_fsm: sequences one data-memory access per EX/MEM instruction.
// Owns the req/ack handshake, the captured load data and the stall term.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_mem_read/i_mem_write EX/MEM control bits of the current instruction
//   i_addr, i_wdata       EX/MEM address and store data (held while stalled)
//   o_req/o_we/o_addr/o_wdata  memory request bus
//   i_ack, i_rdata        memory completion and load data
//   o_rdata               load data captured on ack
//   o_stall               freeze request for the upstream pipeline
//   o_misalign            one-cycle flag for a rejected misaligned access
// Optional feature MEM_ALIGN_CHK_EN: misaligned accesses skip the memory
// and go straight to DONE with o_misalign set; otherwise o_misalign is 0.
module dmem_access_fsm
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_req,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic              i_ack,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_stall,
    output logic              o_misalign
);

    mem_state_t        r_state;
    logic              r_req;
    logic [DATA_W-1:0] r_rdata;
    logic              w_mem_op;

`ifdef MEM_ALIGN_CHK_EN
    logic w_misaligned;
    logic r_misalign;
    assign w_misaligned = (i_addr[1:0] != 2'b00);
    assign o_misalign   = r_misalign;
`else
    assign o_misalign   = 1'b0;
`endif

    assign w_mem_op = i_mem_read | i_mem_write;

    // The stall releases in DONE so the finished instruction retires into
    // MEM/WB on that edge while the next one enters EX/MEM.
    assign o_stall  = w_mem_op & (r_state != ST_DONE);

    // EX/MEM is frozen while stalled, so these stay stable during REQ.
    assign o_req    = r_req;
    assign o_we     = i_mem_write;
    assign o_addr   = i_addr;
    assign o_wdata  = i_wdata;
    assign o_rdata  = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_rdata    <= '0;
`ifdef MEM_ALIGN_CHK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
`ifdef MEM_ALIGN_CHK_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_op) begin
`ifdef MEM_ALIGN_CHK_EN
                        if (w_misaligned) begin
                            r_state    <= ST_DONE;
                            r_misalign <= 1'b1;
                        end else begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
                        end
`else
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
`endif
                    end
                end
                ST_REQ: begin
                    // No timeout: wait for the memory as long as it takes.
                    if (i_ack) begin
                        r_state <= ST_DONE;
                        r_req   <= 1'b0;
                        if (i_mem_read) begin
                            r_rdata <= i_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
// Holds the EX/MEM register, the data-memory access FSM and the MEM/WB
// register, and resolves branches from EX/MEM contents.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   EX_*                       results and control bits from EX
//   flush                      load a bubble into EX/MEM
//   dmem_*                     data-memory req/ack bus
//   mem_stall                  freezes PC, IF/ID, ID/EX and EX/MEM
//   PCSrc, EXtoMEM_BranchAddr  branch decision and target for IF
//   EXtoMEM_ALUresult/RegDest/RegWrite   forwarding source from EX/MEM
//   WB_*                       MEM/WB register contents
//   mem_misalign               misaligned-access flag
// Optional feature MEM_ALIGN_CHK_EN: misaligned accesses are rejected,
// flagged on mem_misalign and retire without a register write.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = 32
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     EX_ALUresult,
    input  logic [DATA_W-1:0]     EX_Rt,
    input  logic [REG_ADDR_W-1:0] EX_RegDest,
    input  logic                  EX_zero,
    input  logic [DATA_W-1:0]     EX_BranchAddr,
    input  logic                  EX_MemRead,
    input  logic                  EX_MemWrite,
    input  logic                  EX_RegWrite,
    input  logic                  EX_MemtoReg,
    input  logic                  EX_Branch,
    input  logic                  flush,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  mem_stall,
    output logic                  PCSrc,
    output logic [DATA_W-1:0]     EXtoMEM_BranchAddr,
    output logic [DATA_W-1:0]     EXtoMEM_ALUresult,
    output logic [REG_ADDR_W-1:0] EXtoMEM_RegDest,
    output logic                  EXtoMEM_RegWrite,
    output logic [DATA_W-1:0]     WB_ALUresult,
    output logic [DATA_W-1:0]     WB_ReadData,
    output logic [REG_ADDR_W-1:0] WB_RegDest,
    output logic                  WB_RegWrite,
    output logic                  WB_MemtoReg,
    output logic                  mem_misalign
);

    ctrl_t                 w_ex_ctrl;
    logic                  w_stall;
    logic                  w_misalign;
    logic [DATA_W-1:0]     w_rdata;

    ctrl_t                 r_exmem_ctrl_p1;
    logic [DATA_W-1:0]     r_exmem_alu_p1;
    logic [DATA_W-1:0]     r_exmem_rt_p1;
    logic [DATA_W-1:0]     r_exmem_baddr_p1;
    logic [REG_ADDR_W-1:0] r_exmem_rd_p1;
    logic                  r_exmem_zero_p1;

    logic [DATA_W-1:0]     r_memwb_alu_p2;
    logic [DATA_W-1:0]     r_memwb_rdata_p2;
    logic [REG_ADDR_W-1:0] r_memwb_rd_p2;
    logic                  r_memwb_regwrite_p2;
    logic                  r_memwb_memtoreg_p2;

    assign w_ex_ctrl = {EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemtoReg, EX_Branch};

    // ---- EX/MEM boundary (p1) ----
    // A stall holds every field, which also makes it override flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exmem_ctrl_p1  <= '0;
            r_exmem_alu_p1   <= '0;
            r_exmem_rt_p1    <= '0;
            r_exmem_baddr_p1 <= '0;
            r_exmem_rd_p1    <= '0;
            r_exmem_zero_p1  <= 1'b0;
        end else if (!w_stall) begin
            r_exmem_ctrl_p1  <= ctrl_gate(w_ex_ctrl, flush);
            r_exmem_alu_p1   <= EX_ALUresult;
            r_exmem_rt_p1    <= EX_Rt;
            r_exmem_baddr_p1 <= EX_BranchAddr;
            r_exmem_rd_p1    <= EX_RegDest;
            r_exmem_zero_p1  <= EX_zero;
        end
    end

    dmem_access_fsm #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dmem_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_read  (r_exmem_ctrl_p1.MemRead),
        .i_mem_write (r_exmem_ctrl_p1.MemWrite),
        .i_addr      (r_exmem_alu_p1[ADDR_W-1:0]),
        .i_wdata     (r_exmem_rt_p1),
        .o_req       (dmem_req),
        .o_we        (dmem_we),
        .o_addr      (dmem_addr),
        .o_wdata     (dmem_wdata),
        .i_ack       (dmem_ack),
        .i_rdata     (dmem_rdata),
        .o_rdata     (w_rdata),
        .o_stall     (w_stall),
        .o_misalign  (w_misalign)
    );

    // ---- MEM/WB boundary (p2) ----
    // While stalled a bubble enters so the instruction writes back only once,
    // on the edge that leaves DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memwb_alu_p2      <= '0;
            r_memwb_rdata_p2    <= '0;
            r_memwb_rd_p2       <= '0;
            r_memwb_regwrite_p2 <= 1'b0;
            r_memwb_memtoreg_p2 <= 1'b0;
        end else if (w_stall) begin
            r_memwb_regwrite_p2 <= 1'b0;
            r_memwb_memtoreg_p2 <= 1'b0;
        end else begin
            r_memwb_alu_p2      <= r_exmem_alu_p1;
            r_memwb_rd_p2       <= r_exmem_rd_p1;
            r_memwb_regwrite_p2 <= r_exmem_ctrl_p1.RegWrite & ~w_misalign;
            r_memwb_memtoreg_p2 <= r_exmem_ctrl_p1.MemtoReg;
            if (r_exmem_ctrl_p1.MemRead) begin
                r_memwb_rdata_p2 <= w_rdata;
            end
        end
    end

    assign mem_stall          = w_stall;
    assign mem_misalign       = w_misalign;
    assign PCSrc              = r_exmem_ctrl_p1.Branch & r_exmem_zero_p1;
    assign EXtoMEM_BranchAddr = r_exmem_baddr_p1;
    assign EXtoMEM_ALUresult  = r_exmem_alu_p1;
    assign EXtoMEM_RegDest    = r_exmem_rd_p1;
    assign EXtoMEM_RegWrite   = r_exmem_ctrl_p1.RegWrite;
    assign WB_ALUresult       = r_memwb_alu_p2;
    assign WB_ReadData        = r_memwb_rdata_p2;
    assign WB_RegDest         = r_memwb_rd_p2;
    assign WB_RegWrite        = r_memwb_regwrite_p2;
    assign WB_MemtoReg        = r_memwb_memtoreg_p2;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] EX_ALUresult, EX_Rt, EX_BranchAddr;
    logic [4:0]  EX_RegDest;
    logic        EX_zero, EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemtoReg, EX_Branch;
    logic        flush;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_stall, PCSrc, mem_misalign;
    logic [31:0] EXtoMEM_BranchAddr, EXtoMEM_ALUresult;
    logic [4:0]  EXtoMEM_RegDest;
    logic        EXtoMEM_RegWrite;
    logic [31:0] WB_ALUresult, WB_ReadData;
    logic [4:0]  WB_RegDest;
    logic        WB_RegWrite, WB_MemtoReg;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic        m2r;
        logic [31:0] rdata;
    } wb_t;

    wb_t obs_q[$];
    wb_t exp_q[$];

    // memory device model and responder controls
    logic [31:0] mem_dev [16];
    logic        resp_en  = 1'b1;
    logic        rand_lat = 1'b0;
    int          lat      = 0;
    int          cur_lat  = 0;
    int          wcnt     = 0;
    logic        rprev    = 1'b0;

    // monitor counters
    int          stall_cnt, req_cnt, addr_chg, m2r_cnt, mis_cnt;
    logic        mprev;
    logic [31:0] aprev, last_addr, last_wdata;
    logic        last_we;

    mem_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .EX_ALUresult       (EX_ALUresult),
        .EX_Rt              (EX_Rt),
        .EX_RegDest         (EX_RegDest),
        .EX_zero            (EX_zero),
        .EX_BranchAddr      (EX_BranchAddr),
        .EX_MemRead         (EX_MemRead),
        .EX_MemWrite        (EX_MemWrite),
        .EX_RegWrite        (EX_RegWrite),
        .EX_MemtoReg        (EX_MemtoReg),
        .EX_Branch          (EX_Branch),
        .flush              (flush),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .mem_stall          (mem_stall),
        .PCSrc              (PCSrc),
        .EXtoMEM_BranchAddr (EXtoMEM_BranchAddr),
        .EXtoMEM_ALUresult  (EXtoMEM_ALUresult),
        .EXtoMEM_RegDest    (EXtoMEM_RegDest),
        .EXtoMEM_RegWrite   (EXtoMEM_RegWrite),
        .WB_ALUresult       (WB_ALUresult),
        .WB_ReadData        (WB_ReadData),
        .WB_RegDest         (WB_RegDest),
        .WB_RegWrite        (WB_RegWrite),
        .WB_MemtoReg        (WB_MemtoReg),
        .mem_misalign       (mem_misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Memory responder: acks after cur_lat waiting REQ cycles.
    initial begin
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                dmem_ack = 1'b0;
                if (dmem_req) begin
                    if (!rprev) begin
                        cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
                        wcnt    = 0;
                    end
                    if (wcnt >= cur_lat) begin
                        dmem_ack = 1'b1;
                        if (dmem_we) mem_dev[dmem_addr[5:2]] = dmem_wdata;
                        else         dmem_rdata = mem_dev[dmem_addr[5:2]];
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end
            rprev = dmem_req;
        end
    end

    // Monitor: counts events and records writebacks.
    initial begin
        mprev = 1'b0;
        aprev = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_stall) stall_cnt++;
            if (mem_misalign) mis_cnt++;
            if (WB_MemtoReg) m2r_cnt++;
            if (dmem_req && !mprev) begin
                req_cnt++;
                last_addr  = dmem_addr;
                last_we    = dmem_we;
                last_wdata = dmem_wdata;
            end
            if (dmem_req && mprev && (dmem_addr != aprev)) addr_chg++;
            if (WB_RegWrite) obs_q.push_back('{WB_RegDest, WB_ALUresult, WB_MemtoReg, WB_ReadData});
            mprev = dmem_req;
            aprev = dmem_addr;
        end
    end

    task automatic clear_mon();
        stall_cnt = 0; req_cnt = 0; addr_chg = 0; m2r_cnt = 0; mis_cnt = 0;
        last_addr = 32'h0; last_we = 1'b0; last_wdata = 32'h0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic drive_nop();
        EX_ALUresult = 32'h0; EX_Rt = 32'h0; EX_BranchAddr = 32'h0; EX_RegDest = 5'd0;
        EX_zero = 1'b0; EX_MemRead = 1'b0; EX_MemWrite = 1'b0; EX_RegWrite = 1'b0;
        EX_MemtoReg = 1'b0; EX_Branch = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one instruction and returns #1 after the edge that captures it.
    task automatic issue(input logic rd_, input logic wr, input logic rw, input logic m2r,
                         input logic br, input logic [31:0] alu, input logic [31:0] rt,
                         input logic [31:0] ba, input logic [4:0] dst, input logic z,
                         input logic fl);
        int n;
        EX_MemRead = rd_; EX_MemWrite = wr; EX_RegWrite = rw; EX_MemtoReg = m2r;
        EX_Branch = br; EX_ALUresult = alu; EX_Rt = rt; EX_BranchAddr = ba;
        EX_RegDest = dst; EX_zero = z; flush = fl;
        n = 0;
        @(negedge clk);
        while (mem_stall && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (mem_stall) begin
            errors++; checks++;
            $display("FAIL issue_timeout mem_stall still 1 after %0d cycles, required 0", n);
        end
        @(posedge clk);
        #1;
        drive_nop();
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        drive_nop();
        #12;
        checks++;
        if ({dmem_req, mem_stall, mem_misalign, PCSrc} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl got %b required 0000", {dmem_req, mem_stall, mem_misalign, PCSrc});
        end
        checks++;
        if ({WB_RegWrite, WB_MemtoReg, WB_RegDest, WB_ALUresult, WB_ReadData} !== 71'b0) begin
            errors++; $display("FAIL reset_wb got rw=%b m2r=%b rd=%0d alu=%h rdata=%h required all 0",
                                WB_RegWrite, WB_MemtoReg, WB_RegDest, WB_ALUresult, WB_ReadData);
        end
        checks++;
        if ({EXtoMEM_RegWrite, EXtoMEM_RegDest, EXtoMEM_ALUresult, EXtoMEM_BranchAddr} !== 70'b0) begin
            errors++; $display("FAIL reset_exmem got rw=%b rd=%0d alu=%h ba=%h required all 0",
                                EXtoMEM_RegWrite, EXtoMEM_RegDest, EXtoMEM_ALUresult, EXtoMEM_BranchAddr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // reset in the middle of a pending read
        lat = 50;
        issue(1, 0, 1, 1, 0, 32'h48, 32'h0, 32'h0, 5'd3, 0, 0);
        n = 0;
        @(negedge clk);
        while (!dmem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++; $display("FAIL reset_midreq_setup dmem_req=%b required 1", dmem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_req, mem_stall} !== 2'b00) begin
            errors++; $display("FAIL reset_async req=%b stall=%b required 0 0 without a clock", dmem_req, mem_stall);
        end
        checks++;
        if ({EXtoMEM_RegWrite, EXtoMEM_ALUresult, WB_RegWrite} !== 34'b0) begin
            errors++; $display("FAIL reset_async_regs exrw=%b exalu=%h wbrw=%b required 0",
                                EXtoMEM_RegWrite, EXtoMEM_ALUresult, WB_RegWrite);
        end
        resp_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hBAD0BAD0;
        idle(2);
        checks++;
        if ({dmem_req, mem_stall, WB_RegWrite} !== 3'b000 || WB_ReadData !== 32'h0) begin
            errors++; $display("FAIL late_ack req=%b stall=%b wbrw=%b rdata=%h required 0 0 0 00000000",
                                dmem_req, mem_stall, WB_RegWrite, WB_ReadData);
        end
        dmem_ack = 1'b0;
        resp_en = 1'b1;
        lat = 0;
        idle(1);
    endtask

    task automatic test_alu();
        clear_mon();
        issue(0, 0, 1, 0, 0, 32'h15, 32'h0, 32'h0, 5'd8, 0, 0);
        checks++;
        if (EXtoMEM_ALUresult !== 32'h15 || EXtoMEM_RegDest !== 5'd8 || EXtoMEM_RegWrite !== 1'b1) begin
            errors++; $display("FAIL alu_exmem got alu=%h rd=%0d rw=%b required 15 8 1",
                                EXtoMEM_ALUresult, EXtoMEM_RegDest, EXtoMEM_RegWrite);
        end
        idle(1);
        checks++;
        if (WB_ALUresult !== 32'h15 || WB_RegDest !== 5'd8 || WB_RegWrite !== 1'b1 || WB_MemtoReg !== 1'b0) begin
            errors++; $display("FAIL alu_wb got alu=%h rd=%0d rw=%b m2r=%b required 15 8 1 0",
                                WB_ALUresult, WB_RegDest, WB_RegWrite, WB_MemtoReg);
        end
        idle(2);
        checks++;
        if (stall_cnt != 0 || obs_q.size() != 1) begin
            errors++; $display("FAIL alu_nostall got stalls=%0d writebacks=%0d required 0 1", stall_cnt, obs_q.size());
        end
    endtask

    task automatic test_lw();
        clear_mon();
        mem_dev[0] = 32'hDEADBEEF;
        lat = 2;
        issue(1, 0, 1, 1, 0, 32'h40, 32'h0, 32'h0, 5'd9, 0, 0);
        idle(8);
        checks++;
        if (stall_cnt != 4) begin
            errors++; $display("FAIL lw_stall got %0d stall cycles required 4", stall_cnt);
        end
        checks++;
        if (req_cnt != 1 || addr_chg != 0 || last_addr !== 32'h40 || last_we !== 1'b0) begin
            errors++; $display("FAIL lw_req got reqs=%0d addr_changes=%0d addr=%h we=%b required 1 0 40 0",
                                req_cnt, addr_chg, last_addr, last_we);
        end
        checks++;
        if (m2r_cnt != 1 || obs_q.size() != 1) begin
            errors++; $display("FAIL lw_once got m2r_cycles=%0d writebacks=%0d required 1 1", m2r_cnt, obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].rdata !== 32'hDEADBEEF || obs_q[0].rd !== 5'd9 || obs_q[0].m2r !== 1'b1) begin
                errors++; $display("FAIL lw_data got rdata=%h rd=%0d m2r=%b required deadbeef 9 1",
                                    obs_q[0].rdata, obs_q[0].rd, obs_q[0].m2r);
            end
        end
        lat = 0;
    endtask

    task automatic test_sw();
        clear_mon();
        mem_dev[1] = 32'h0;
        lat = 0;
        issue(0, 1, 0, 0, 0, 32'h44, 32'h1234, 32'h0, 5'd0, 0, 0);
        idle(6);
        checks++;
        if (req_cnt != 1 || last_we !== 1'b1 || last_wdata !== 32'h1234 || last_addr !== 32'h44) begin
            errors++; $display("FAIL sw_req got reqs=%0d we=%b wdata=%h addr=%h required 1 1 1234 44",
                                req_cnt, last_we, last_wdata, last_addr);
        end
        checks++;
        if (stall_cnt != 2 || obs_q.size() != 0) begin
            errors++; $display("FAIL sw_stall got stalls=%0d writebacks=%0d required 2 0", stall_cnt, obs_q.size());
        end
        checks++;
        if (mem_dev[1] !== 32'h1234) begin
            errors++; $display("FAIL sw_mem got %h required 1234", mem_dev[1]);
        end
    endtask

    task automatic test_beq();
        clear_mon();
        issue(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h100, 5'd0, 1, 0);
        checks++;
        if (PCSrc !== 1'b1 || EXtoMEM_BranchAddr !== 32'h100) begin
            errors++; $display("FAIL beq_taken got pcsrc=%b target=%h required 1 100", PCSrc, EXtoMEM_BranchAddr);
        end
        issue(1, 0, 1, 1, 1, 32'h50, 32'h0, 32'h200, 5'd7, 1, 1);
        checks++;
        if (PCSrc !== 1'b0 || EXtoMEM_RegWrite !== 1'b0 || EXtoMEM_ALUresult !== 32'h50 || EXtoMEM_BranchAddr !== 32'h200) begin
            errors++; $display("FAIL flush_bubble got pcsrc=%b rw=%b alu=%h ba=%h required 0 0 50 200",
                                PCSrc, EXtoMEM_RegWrite, EXtoMEM_ALUresult, EXtoMEM_BranchAddr);
        end
        idle(4);
        checks++;
        if (req_cnt != 0 || stall_cnt != 0 || obs_q.size() != 0) begin
            errors++; $display("FAIL flush_noeffect got reqs=%0d stalls=%0d writebacks=%0d required 0 0 0",
                                req_cnt, stall_cnt, obs_q.size());
        end
    endtask

    task automatic test_stall_flush();
        clear_mon();
        mem_dev[2] = 32'h5A5A0002;
        lat = 1;
        issue(1, 0, 1, 1, 0, 32'h48, 32'h0, 32'h0, 5'd10, 0, 0);
        EX_ALUresult = 32'h77; EX_RegWrite = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (EXtoMEM_ALUresult !== 32'h48 || EXtoMEM_RegWrite !== 1'b1 || EXtoMEM_RegDest !== 5'd10) begin
            errors++; $display("FAIL stall_beats_flush got alu=%h rw=%b rd=%0d required 48 1 10",
                                EXtoMEM_ALUresult, EXtoMEM_RegWrite, EXtoMEM_RegDest);
        end
        drive_nop();
        idle(6);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL stall_flush_wb got %0d writebacks required 1", obs_q.size());
        end else if (obs_q[0].rdata !== 32'h5A5A0002) begin
            errors++; $display("FAIL stall_flush_data got %h required 5a5a0002", obs_q[0].rdata);
        end
        lat = 0;
    endtask

    task automatic test_misalign();
        clear_mon();
        lat = 0;
        issue(1, 0, 1, 1, 0, 32'h42, 32'h0, 32'h0, 5'd11, 0, 0);
        idle(6);
`ifdef MEM_ALIGN_CHK_EN
        checks++;
        if (req_cnt != 0 || mis_cnt != 1) begin
            errors++; $display("FAIL misalign_flag got reqs=%0d misalign_cycles=%0d required 0 1", req_cnt, mis_cnt);
        end
        checks++;
        if (obs_q.size() != 0 || stall_cnt != 1) begin
            errors++; $display("FAIL misalign_wb got writebacks=%0d stalls=%0d required 0 1", obs_q.size(), stall_cnt);
        end
`else
        checks++;
        if (req_cnt != 1 || last_addr !== 32'h42 || mis_cnt != 0) begin
            errors++; $display("FAIL misalign_pass got reqs=%0d addr=%h misalign_cycles=%0d required 1 42 0",
                                req_cnt, last_addr, mis_cnt);
        end
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL misalign_pass_wb got %0d writebacks required 1", obs_q.size());
        end
`endif
    endtask

    // Random instruction stream against a program-order reference model.
    task automatic test_back_to_back();
        logic [31:0] ref_mem [16];
        logic [31:0] val, addr;
        logic [3:0]  idx;
        logic [4:0]  dst;
        int          kind, nmem, nmin;
        clear_mon();
        for (int i = 0; i < 16; i++) begin
            mem_dev[i] = 32'hC0DE0000 + 32'(i);
            ref_mem[i] = 32'hC0DE0000 | 32'(i);
        end
        rand_lat = 1'b1;
        nmem = 0;
        for (int k = 0; k < 60; k++) begin
            kind = int'($urandom_range(0, 3));
            idx  = 4'($urandom_range(0, 15));
            dst  = 5'($urandom_range(1, 31));
            val  = $urandom;
            addr = 32'h200 + 32'(idx) * 4;
            case (kind)
                1: begin
                    exp_q.push_back('{dst, val, 1'b0, 32'h0});
                    issue(0, 0, 1, 0, 0, val, 32'h0, 32'h0, dst, 0, 0);
                end
                2: begin
                    exp_q.push_back('{dst, addr, 1'b1, ref_mem[idx]});
                    nmem++;
                    issue(1, 0, 1, 1, 0, addr, 32'h0, 32'h0, dst, 0, 0);
                end
                3: begin
                    ref_mem[idx] = val;
                    nmem++;
                    issue(0, 1, 0, 0, 0, addr, val, 32'h0, dst, 0, 0);
                end
                default: issue(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0);
            endcase
        end
        idle(12);
        rand_lat = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size() || req_cnt != nmem || mis_cnt != 0) begin
            errors++; $display("FAIL stream_counts got writebacks=%0d reqs=%0d misalign=%0d required %0d %0d 0",
                                obs_q.size(), req_cnt, mis_cnt, exp_q.size(), nmem);
        end
        nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            checks++;
            if (obs_q[i].rd !== exp_q[i].rd || obs_q[i].alu !== exp_q[i].alu || obs_q[i].m2r !== exp_q[i].m2r ||
                (exp_q[i].m2r && obs_q[i].rdata !== exp_q[i].rdata)) begin
                errors++; $display("FAIL stream_wb[%0d] got rd=%0d alu=%h m2r=%b rdata=%h required rd=%0d alu=%h m2r=%b rdata=%h",
                                    i, obs_q[i].rd, obs_q[i].alu, obs_q[i].m2r, obs_q[i].rdata,
                                    exp_q[i].rd, exp_q[i].alu, exp_q[i].m2r, exp_q[i].rdata);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_dev[i] = 32'h0;
        clear_mon();
        test_reset();
        test_alu();
        test_lw();
        test_sw();
        test_beq();
        test_stall_flush();
        test_misalign();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline. Sits directly downstream of EX_Stage and consumes its ALUresult, EX_Rt (store data), RegDest, zero and Branch_Addr.
- Contains the EX/MEM pipeline register, a data-memory access FSM with a req/ack handshake and pipeline stall, and the MEM/WB pipeline register.
- Produces EXtoMEM_ALUresult and WB_ALUresult, the forwarding sources EX_Stage selects with ForwardA/ForwardB.

Parameters:
- DATA_W, 32, datapath and memory data width.
- ADDR_W, 32, data-memory address width; low ADDR_W bits of ALUresult.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- EX_ALUresult  in  DATA_W  ALU result / memory address from EX.
- EX_Rt  in  DATA_W  forwarded store data from EX.
- EX_RegDest  in  5  destination register from EX.
- EX_zero  in  1  ALU zero flag.
- EX_BranchAddr  in  DATA_W  computed branch target.
- EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemtoReg, EX_Branch  in  1 each  control bits.
- flush  in  1  load a bubble into EX/MEM instead of EX values.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  memory address.
- dmem_wdata  out  DATA_W  write data.
- dmem_ack  in  1  request complete; rdata valid this cycle for reads.
- dmem_rdata  in  DATA_W  read data.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- PCSrc  out  1  branch taken.
- EXtoMEM_BranchAddr  out  DATA_W  branch target to IF.
- EXtoMEM_ALUresult  out  DATA_W  forwarding source.
- EXtoMEM_RegDest  out  5  forwarding source.
- EXtoMEM_RegWrite  out  1  forwarding source.
- WB_ALUresult  out  DATA_W  MEM/WB ALU result.
- WB_ReadData  out  DATA_W  MEM/WB load data.
- WB_RegDest  out  5  MEM/WB destination register.
- WB_RegWrite  out  1  MEM/WB control.
- WB_MemtoReg  out  1  MEM/WB control.
- mem_misalign  out  1  see Optional Feature.

Behaviour:
- Reset (async, rst_n=0): all EX/MEM and MEM/WB registers = 0; FSM = IDLE; captured read-data register = 0; dmem_req = 0; mem_stall = 0; mem_misalign = 0. An in-flight request is abandoned immediately; a late dmem_ack after reset is ignored.
- mem_op = EXtoMEM_MemRead | EXtoMEM_MemWrite.
- EX/MEM register updates on the rising edge only when mem_stall = 0:
  - flush = 1: load data fields; force MemRead, MemWrite, RegWrite, MemtoReg, Branch to 0.
  - mem_stall = 1: all EX/MEM fields hold.
- FSM states: IDLE, REQ, DONE.
  - IDLE: mem_op = 1 -> REQ. Otherwise stay in IDLE.
  - REQ: dmem_req = 1. dmem_we, dmem_addr, dmem_wdata are driven from EX/MEM and stay stable while waiting. On dmem_ack = 1: capture dmem_rdata (reads only), go to DONE. No timeout.
  - DONE: single cycle, unconditionally -> IDLE.
  - dmem_ack outside REQ is ignored.
- mem_stall = mem_op & (state != DONE).
  - Minimum cost of an access with ack in the first REQ cycle: 2 stall cycles.
  - Non-memory instructions: zero stall.
- MEM/WB register updates when mem_stall = 0:
  - Loads ALUresult, RegDest, RegWrite, MemtoReg.
  - WB_ReadData = captured read data for a read; otherwise holds its previous value (don't-care).
  - While stalled, MEM/WB loads a bubble (WB_RegWrite = 0). This prevents a duplicate writeback.
- PCSrc = EXtoMEM_Branch & EX/MEM zero. Combinational from EX/MEM, so branch resolves in MEM. The hazard unit drives flush.
- Simultaneous flush and mem_stall: the stall wins; flush is ignored that cycle.
- All widths are fixed; there is no arithmetic in this block.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined:
  - A mem_op with dmem_addr[1:0] != 0 never asserts dmem_req; the FSM goes IDLE -> DONE.
  - mem_misalign = 1 for that DONE cycle.
  - The MEM/WB entry is written with RegWrite = 0.
- Undefined: mem_misalign is tied 0 and all addresses are passed to memory unchanged.

Decomposition:
- Shared package mips_pkg:
  - FSM state encoding (IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2).
  - DATA_W and REG_ADDR_W = 5 constants.
  - Control-bundle struct {MemRead, MemWrite, RegWrite, MemtoReg, Branch} shared with the ID/EX register.
- One natural sub-module: dmem_access_fsm. It owns the state, dmem_* outputs, the read-data capture and the stall term.
- The pipeline registers stay in mem_stage.

Test Plan:
- Reset mid-REQ: assert rst_n = 0 with dmem_req = 1 -> dmem_req drops without waiting for a clock; all WB_* = 0; state = IDLE.
- ALU op, no memory: EX_ALUresult = 32'h15, RegDest = 5'd8, RegWrite = 1 -> EXtoMEM_ALUresult = 32'h15 after 1 edge; WB_ALUresult = 32'h15, WB_RegWrite = 1 after 2 edges; mem_stall never high.
- lw, addr 32'h40, ack after 3 REQ cycles with rdata = 32'hDEADBEEF:
  - mem_stall high for 4 cycles.
  - dmem_addr stable at 32'h40 throughout.
  - WB_ReadData = 32'hDEADBEEF and WB_MemtoReg = 1 for exactly one cycle; bubbles before it.
- sw, addr 32'h44, EX_Rt = 32'h1234, immediate ack -> dmem_we = 1, dmem_wdata = 32'h1234; exactly one request; 2 stall cycles; WB_RegWrite = 0.
- beq with EX_zero = 1, Branch = 1, EX_BranchAddr = 32'h100:
  - PCSrc = 1 and EXtoMEM_BranchAddr = 32'h100 one edge later.
  - With flush asserted on the next edge, EX/MEM controls are 0.
- MEM_ALIGN_CHK_EN defined, lw to 32'h42:
  - No dmem_req.
  - mem_misalign pulses for 1 cycle.
  - WB_RegWrite = 0.
